// File: rtl/index_handler_mc.sv
// index_handler_mc: multi-drive index pulse handler.
// Each drive channel has its own logic, which does the following:
//   - synchronises and deglitches the raw index input
//   - times each revolution exactly, in clk cycles
//   - checks the revolution time against a tolerance window
//   - keeps an exponential moving average (EMA) of in-tolerance revolution times
// One sequential divider is shared round-robin across the drives. It turns each
// drive's average into a true RPM value.
//
// Ports (N = NUM_DRIVES):
//   clk, reset          system clock, synchronous active-high reset
//   enable              global advance enable; all state holds while low
//   index_raw[N]        raw index input per drive
//   motor_running[N]    motor-on per drive
//   rpm_360[N]          1 = 360 RPM expected, 0 = 300 RPM
//   index_pulse[N]      1-cycle accepted index rising edge
//   index_level[N]      deglitched index level
//   first_index[N]      1-cycle, first index after motor start or timeout
//   revolution_time[N]  last measured interval (32 bit)
//   avg_rev_time[N]     EMA of in-tolerance intervals (32 bit)
//   revolution_count[N] accepted indexes since motor start, saturating (16 bit)
//   disk_rotating[N]    last interval in tolerance and no timeout since
//   rpm_error[N]        last interval out of tolerance
//   rpm_measured[N]     60*CLK_FREQ_HZ / avg_rev_time, saturating at 1023 (10 bit)
//   rpm_valid[N]        rpm_measured is current for this spin-up

// Per-drive channel: input filtering, interval timing, tolerance, EMA, RPM result
// register. The shared divider clears pending and writes the RPM result through
// pend_clr / rpm_wr.
module index_handler_mc_drive #(
    parameter int CLK_FREQ_HZ     = 200_000_000,
    parameter int DEGLITCH_CYCLES = 200,
    parameter int AVG_SHIFT       = 2,
    parameter int TOL_SHIFT       = 4,
    parameter int TIMEOUT_CYCLES  = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        index_raw,
    input  logic        motor_running,
    input  logic        rpm_360,
    input  logic        pend_clr,
    input  logic        rpm_wr,
    input  logic [9:0]  rpm_wr_val,
    output logic        index_pulse,
    output logic        index_level,
    output logic        first_index,
    output logic [31:0] revolution_time,
    output logic [31:0] avg_rev_time,
    output logic [15:0] revolution_count,
    output logic        disk_rotating,
    output logic        rpm_error,
    output logic [9:0]  rpm_measured,
    output logic        rpm_valid,
    output logic        pending,
    output logic        motor_rise
);
    localparam int          DW     = $clog2(DEGLITCH_CYCLES + 1);
    localparam logic [31:0] EXP300 = 32'(CLK_FREQ_HZ / 5);
    localparam logic [31:0] EXP360 = 32'(CLK_FREQ_HZ / 6);
    localparam logic [31:0] TO     = 32'(TIMEOUT_CYCLES);

    logic          sync1, sync2, filt, filt_q, motor_q;
    logic [DW-1:0] dg_cnt;
    logic [31:0]   cnt, interval, exp_t, tol_t, ema_next;
    logic          awaiting_first, ema_loaded, event_w, in_tol;

    assign index_level = filt;
    assign event_w     = filt & ~filt_q;
    assign motor_rise  = enable & motor_running & ~motor_q;
    // cnt was cleared on the previous event, so cnt+1 is the exact cycle distance.
    assign interval    = cnt + 32'd1;
    assign exp_t       = rpm_360 ? EXP360 : EXP300;
    assign tol_t       = exp_t >> TOL_SHIFT;
    assign in_tol      = (interval >= exp_t - tol_t) && (interval <= exp_t + tol_t);
    assign ema_next    = avg_rev_time - (avg_rev_time >> AVG_SHIFT) + (interval >> AVG_SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1            <= 1'b0;
            sync2            <= 1'b0;
            filt             <= 1'b0;
            filt_q           <= 1'b0;
            motor_q          <= 1'b0;
            dg_cnt           <= '0;
            cnt              <= '0;
            awaiting_first   <= 1'b1;
            ema_loaded       <= 1'b0;
            pending          <= 1'b0;
            index_pulse      <= 1'b0;
            first_index      <= 1'b0;
            revolution_time  <= '0;
            avg_rev_time     <= '0;
            revolution_count <= '0;
            disk_rotating    <= 1'b0;
            rpm_error        <= 1'b0;
            rpm_measured     <= '0;
            rpm_valid        <= 1'b0;
        end else if (!enable) begin
            index_pulse <= 1'b0;
            first_index <= 1'b0;
        end else begin
            sync1   <= index_raw;
            sync2   <= sync1;
            filt_q  <= filt;
            motor_q <= motor_running;
            // The filtered level flips on the DEGLITCH_CYCLES-th consecutive differing sample.
            if (sync2 != filt) begin
                if (dg_cnt == DW'(DEGLITCH_CYCLES - 1)) begin
                    filt   <= sync2;
                    dg_cnt <= '0;
                end else begin
                    dg_cnt <= dg_cnt + 1'b1;
                end
            end else begin
                dg_cnt <= '0;
            end

            index_pulse <= 1'b0;
            first_index <= 1'b0;
            // Later assignments win: a fresh EMA update re-arms pending over a divider clear.
            if (pend_clr) pending <= 1'b0;
            if (rpm_wr) begin
                rpm_measured <= rpm_wr_val;
                rpm_valid    <= 1'b1;
            end

            if (motor_rise) begin
                awaiting_first   <= 1'b1;
                cnt              <= '0;
                revolution_count <= '0;
                disk_rotating    <= 1'b0;
                rpm_valid        <= 1'b0;
                ema_loaded       <= 1'b0;
                pending          <= 1'b0;
            end else if (!motor_running) begin
                disk_rotating <= 1'b0;
                rpm_error     <= 1'b0;
                cnt           <= '0;
            end else if (event_w) begin
                index_pulse <= 1'b1;
                cnt         <= '0;
                if (revolution_count != 16'hFFFF) revolution_count <= revolution_count + 16'd1;
                if (awaiting_first) begin
                    first_index    <= 1'b1;
                    awaiting_first <= 1'b0;
                end else begin
                    revolution_time <= interval;
                    if (in_tol) begin
                        disk_rotating <= 1'b1;
                        rpm_error     <= 1'b0;
                        pending       <= 1'b1;
                        ema_loaded    <= 1'b1;
                        avg_rev_time  <= ema_loaded ? ema_next : interval;
                    end else begin
                        rpm_error     <= 1'b1;
                        disk_rotating <= 1'b0;
                    end
                end
            end else if (cnt >= TO - 32'd1) begin
                // Timeout: saturate the counter and re-arm first-index detection.
                cnt            <= TO;
                disk_rotating  <= 1'b0;
                rpm_valid      <= 1'b0;
                awaiting_first <= 1'b1;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end
endmodule

module index_handler_mc #(
    parameter int NUM_DRIVES      = 2,
    parameter int CLK_FREQ_HZ     = 200_000_000,
    parameter int DEGLITCH_CYCLES = 200,
    parameter int AVG_SHIFT       = 2,
    parameter int TOL_SHIFT       = 4,
    parameter int TIMEOUT_CYCLES  = 100_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_DRIVES-1:0]       index_raw,
    input  logic [NUM_DRIVES-1:0]       motor_running,
    input  logic [NUM_DRIVES-1:0]       rpm_360,
    output logic [NUM_DRIVES-1:0]       index_pulse,
    output logic [NUM_DRIVES-1:0]       index_level,
    output logic [NUM_DRIVES-1:0]       first_index,
    output logic [NUM_DRIVES-1:0][31:0] revolution_time,
    output logic [NUM_DRIVES-1:0][31:0] avg_rev_time,
    output logic [NUM_DRIVES-1:0][15:0] revolution_count,
    output logic [NUM_DRIVES-1:0]       disk_rotating,
    output logic [NUM_DRIVES-1:0]       rpm_error,
    output logic [NUM_DRIVES-1:0][9:0]  rpm_measured,
    output logic [NUM_DRIVES-1:0]       rpm_valid
);
    localparam int          DRV_W    = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;
    localparam logic [35:0] DIVIDEND = 36'(CLK_FREQ_HZ) * 36'd60;

    typedef enum logic [1:0] {IDLE, LOAD, DIV, WRITE} div_state_t;

    div_state_t                state, state_nx;
    logic [NUM_DRIVES-1:0]     pending, motor_rise, pend_clr, rpm_wr;
    logic [9:0]                rpm_wr_val;
    logic [DRV_W-1:0]          cur, last, grant_idx;
    logic                      grant_vld, stale, q_bit;
    logic [31:0]               dvsr, rem, rem_nx;
    logic [32:0]               rem_sh;
    logic [35:0]               dq;     // dividend shifts out the top, quotient shifts in
    logic [5:0]                it;

    for (genvar g = 0; g < NUM_DRIVES; g++) begin : g_drv
        index_handler_mc_drive #(
            .CLK_FREQ_HZ     (CLK_FREQ_HZ),
            .DEGLITCH_CYCLES (DEGLITCH_CYCLES),
            .AVG_SHIFT       (AVG_SHIFT),
            .TOL_SHIFT       (TOL_SHIFT),
            .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
        ) u_drv (
            .clk              (clk),
            .reset            (reset),
            .enable           (enable),
            .index_raw        (index_raw[g]),
            .motor_running    (motor_running[g]),
            .rpm_360          (rpm_360[g]),
            .pend_clr         (pend_clr[g]),
            .rpm_wr           (rpm_wr[g]),
            .rpm_wr_val       (rpm_wr_val),
            .index_pulse      (index_pulse[g]),
            .index_level      (index_level[g]),
            .first_index      (first_index[g]),
            .revolution_time  (revolution_time[g]),
            .avg_rev_time     (avg_rev_time[g]),
            .revolution_count (revolution_count[g]),
            .disk_rotating    (disk_rotating[g]),
            .rpm_error        (rpm_error[g]),
            .rpm_measured     (rpm_measured[g]),
            .rpm_valid        (rpm_valid[g]),
            .pending          (pending[g]),
            .motor_rise       (motor_rise[g])
        );
    end

    // Round-robin: first pending drive strictly after the last-served one.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = last;
        idx       = 0;
        for (int k = 1; k <= NUM_DRIVES; k++) begin
            idx = (int'(last) + k) % NUM_DRIVES;
            if (!grant_vld && pending[idx]) begin
                grant_vld = 1'b1;
                grant_idx = DRV_W'(idx);
            end
        end
    end

    // One restoring-division step.
    assign rem_sh = {rem, dq[35]};
    assign q_bit  = rem_sh >= {1'b0, dvsr};
    assign rem_nx = q_bit ? 32'(rem_sh - {1'b0, dvsr}) : rem_sh[31:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else if (enable) state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_vld) state_nx = LOAD;
            LOAD:    state_nx = DIV;
            DIV:     if (it == 6'd35) state_nx = WRITE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pend_clr   = '0;
        rpm_wr     = '0;
        rpm_wr_val = (dq > 36'd1023) ? 10'd1023 : dq[9:0];
        if (enable && state == LOAD) pend_clr[cur] = 1'b1;
        // A job whose drive was restarted or stopped meanwhile is dropped.
        if (enable && state == WRITE && !stale && motor_running[cur] && !motor_rise[cur])
            rpm_wr[cur] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur   <= '0;
            last  <= DRV_W'(NUM_DRIVES - 1);   // so drive 0 is served first after reset
            stale <= 1'b0;
            dvsr  <= '0;
            rem   <= '0;
            dq    <= '0;
            it    <= '0;
        end else if (enable) begin
            case (state)
                IDLE: if (grant_vld) begin
                    cur   <= grant_idx;
                    last  <= grant_idx;
                    stale <= motor_rise[grant_idx];
                end
                LOAD: begin
                    dvsr <= avg_rev_time[cur];
                    dq   <= DIVIDEND;
                    rem  <= '0;
                    it   <= '0;
                end
                DIV: begin
                    rem <= rem_nx;
                    dq  <= {dq[34:0], q_bit};
                    it  <= it + 6'd1;
                end
                default: ;
            endcase
            if (state != IDLE && motor_rise[cur]) stale <= 1'b1;
        end
    end
endmodule
